aggr_ctrl: RTL and testbench

AGGR_CTRL -- requirements
Module: aggr_ctrl

---
 rtl/aggr_ctrl.sv | 144 ++++++++++++++
 tb/tb_aggr_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/aggr_ctrl.sv
// Tile/layer sequencer for a GNN aggregation unit: LOAD -> AGGR -> WAIT -> COMB per tile.
// Define AGGR_CTRL_TIMEOUT_EN to build the WAIT watchdog and the sticky err flag.
module aggr_ctrl #(
    parameter int NUM_TILES      = 4,
    parameter int NUM_LAYERS     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             start,
    input  logic                                             abort,
    input  logic                                             feat_valid,
    output logic                                             feat_ready,
    output logic                                             in_ready_aggr,
    input  logic                                             out_ready_aggr,
    output logic                                             comb_valid,
    input  logic                                             comb_ready,
    output logic [((NUM_TILES  > 1) ? $clog2(NUM_TILES)  : 1)-1:0] tile_idx,
    output logic [((NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1)-1:0] layer_idx,
    output logic                                             busy,
    output logic                                             done,
    output logic                                             err
);
    localparam int TW = (NUM_TILES  > 1) ? $clog2(NUM_TILES)  : 1;
    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [TW-1:0] TILE_MAX  = TW'(NUM_TILES - 1);
    localparam logic [LW-1:0] LAYER_MAX = LW'(NUM_LAYERS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        AGGR = 3'd2,
        WAIT = 3'd3,
        COMB = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tile_q, tile_d;
    logic [LW-1:0]   layer_q, layer_d;
`ifdef AGGR_CTRL_TIMEOUT_EN
    localparam logic [9:0] CNT_MAX = 10'(TIMEOUT_CYCLES - 1);
    logic [9:0]      wait_cnt_q, wait_cnt_d;
    logic            err_q, err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tile_q     <= '0;
            layer_q    <= '0;
`ifdef AGGR_CTRL_TIMEOUT_EN
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tile_q     <= tile_d;
            layer_q    <= layer_d;
`ifdef AGGR_CTRL_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        tile_d  = tile_q;
        layer_d = layer_q;
`ifdef AGGR_CTRL_TIMEOUT_EN
        err_d      = err_q;
        // Any cycle outside WAIT zeroes the count, so it starts fresh on every entry.
        wait_cnt_d = (state_q == WAIT) ? wait_cnt_q + 10'd1 : '0;
`endif
        if (abort) begin
            state_d = IDLE;
            tile_d  = '0;
            layer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = LOAD;
                        tile_d  = '0;
                        layer_d = '0;
`ifdef AGGR_CTRL_TIMEOUT_EN
                        err_d   = 1'b0;
`endif
                    end
                end
                LOAD: if (feat_valid) state_d = AGGR;
                AGGR: state_d = WAIT;
                WAIT: begin
                    if (out_ready_aggr) begin
                        state_d = COMB;
`ifdef AGGR_CTRL_TIMEOUT_EN
                    end else if (wait_cnt_q == CNT_MAX) begin
                        state_d = ERR;
                        err_d   = 1'b1;
`endif
                    end
                end
                COMB: begin
                    if (comb_ready) begin
                        if (tile_q != TILE_MAX) begin
                            tile_d  = tile_q + 1'b1;
                            state_d = LOAD;
                        end else if (layer_q != LAYER_MAX) begin
                            tile_d  = '0;
                            layer_d = layer_q + 1'b1;
                            state_d = LOAD;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    tile_d  = '0;
                    layer_d = '0;
                end
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        feat_ready    = (state_q == LOAD);
        in_ready_aggr = (state_q == AGGR);
        comb_valid    = (state_q == COMB);
        busy          = (state_q != IDLE);
        done          = (state_q == DONE);
        tile_idx      = tile_q;
        layer_idx     = layer_q;
`ifdef AGGR_CTRL_TIMEOUT_EN
        err           = err_q;
`else
        err           = 1'b0;
`endif
    end
endmodule

// File: tb/tb_aggr_ctrl.sv
// Directed bench for aggr_ctrl at default parameters; timeout scenario follows AGGR_CTRL_TIMEOUT_EN.
module tb_aggr_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, start, abort, feat_valid, out_ready_aggr, comb_ready;
    logic       feat_ready, in_ready_aggr, comb_valid, busy, done, err;
    logic [1:0] tile_idx;
    logic [0:0] layer_idx;
    int errors = 0;
    int checks = 0;

    aggr_ctrl #(.NUM_TILES(4), .NUM_LAYERS(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .feat_valid(feat_valid), .feat_ready(feat_ready),
        .in_ready_aggr(in_ready_aggr), .out_ready_aggr(out_ready_aggr),
        .comb_valid(comb_valid), .comb_ready(comb_ready),
        .tile_idx(tile_idx), .layer_idx(layer_idx),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; abort = 0; feat_valid = 0; out_ready_aggr = 0; comb_ready = 0;
    endtask

    function automatic bit in_wait();
        return busy && !feat_ready && !in_ready_aggr && !comb_valid && !done && !err;
    endfunction

    task automatic wait_comb(input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            if (comb_valid) begin ok = 1; return; end
            tick();
        end
    endtask

    task automatic launch();
        start = 1; tick(); start = 0;
    endtask

    task automatic clear_job();
        abort = 1; tick(); abort = 0;
    endtask

    task automatic test_reset();
        logic [9:0] o;
        idle_inputs();
        rst_n = 0;
        #12;
        o = {feat_ready, in_ready_aggr, comb_valid, busy, done, err, tile_idx, layer_idx};
        checks++; if (o !== 10'd0) begin errors++; $display("FAIL reset_outputs: got %b expected 0", o); end
        #10 rst_n = 1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_full_job();
        int irq = 0, busyc = 0, donec = 0, acc = 0, last_acc = -1, done_cyc = -2;
        bit prev_ir = 0, busy_in_done = 0;
        idle_inputs();
        feat_valid = 1; comb_ready = 1;
        launch();
        for (int c = 0; c < 60; c++) begin
            if (in_ready_aggr) irq++;
            if (busy && !done) busyc++;
            if (comb_valid && comb_ready) begin acc++; last_acc = c; end
            if (done) begin donec++; done_cyc = c; busy_in_done = busy; end
            out_ready_aggr = prev_ir;
            prev_ir = in_ready_aggr;
            tick();
        end
        checks++; if (irq !== 8) begin errors++; $display("FAIL job_in_ready_pulses: got %0d expected 8", irq); end
        checks++; if (acc !== 8) begin errors++; $display("FAIL job_comb_accepts: got %0d expected 8", acc); end
        checks++; if (donec !== 1) begin errors++; $display("FAIL job_done_pulses: got %0d expected 1", donec); end
        checks++; if (done_cyc !== last_acc + 1) begin errors++; $display("FAIL job_done_timing: got cycle %0d expected %0d", done_cyc, last_acc + 1); end
        checks++; if (busyc !== 32) begin errors++; $display("FAIL job_busy_cycles: got %0d expected 32", busyc); end
        checks++; if (busy_in_done !== 1'b1) begin errors++; $display("FAIL job_busy_in_done: got %b expected 1", busy_in_done); end
        checks++; if ({busy, tile_idx, layer_idx} !== 4'd0) begin errors++; $display("FAIL job_end_idle: got %b expected 0000", {busy, tile_idx, layer_idx}); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int vc = 0, bad = 0;
        idle_inputs();
        feat_valid = 1; out_ready_aggr = 1;
        launch();
        for (int t = 0; t < 2; t++) begin
            wait_comb(10, ok);
            comb_ready = 1; tick(); comb_ready = 0;
        end
        wait_comb(10, ok);
        checks++; if (!ok || tile_idx !== 2'd2) begin errors++; $display("FAIL bp_reach_tile2: got ok=%0d tile=%0d expected ok=1 tile=2", ok, tile_idx); end
        for (int i = 0; i < 5; i++) begin
            if (comb_valid) vc++;
            if (tile_idx !== 2'd2 || in_ready_aggr) bad++;
            tick();
        end
        if (comb_valid) vc++;
        comb_ready = 1; tick(); comb_ready = 0;
        checks++; if (vc !== 6) begin errors++; $display("FAIL bp_valid_held: got %0d expected 6", vc); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stall_state: got %0d bad cycles expected 0", bad); end
        checks++; if ({feat_ready, comb_valid, tile_idx} !== 4'b1011) begin errors++; $display("FAIL bp_after_accept: got %b expected 1011", {feat_ready, comb_valid, tile_idx}); end
        clear_job();
    endtask

    task automatic test_abort();
        bit found = 0, sawdone = 0;
        idle_inputs();
        feat_valid = 1; comb_ready = 1; out_ready_aggr = 1;
        launch();
        for (int c = 0; c < 80; c++) begin
            if (done) sawdone = 1;
            if (feat_ready && layer_idx == 1'b1 && tile_idx == 2'd3) out_ready_aggr = 0;
            if (in_wait() && layer_idx == 1'b1 && tile_idx == 2'd3) begin found = 1; break; end
            tick();
        end
        tick();
        checks++; if (!found || !in_wait()) begin errors++; $display("FAIL abort_reach_wait: got found=%0d wait=%0d expected 1/1", found, in_wait()); end
        abort = 1; tick(); abort = 0;
        checks++; if ({busy, done, tile_idx, layer_idx} !== 5'd0) begin errors++; $display("FAIL abort_to_idle: got %b expected 00000", {busy, done, tile_idx, layer_idx}); end
        tick();
        if (done) sawdone = 1;
        checks++; if (sawdone !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", sawdone); end
        launch();
        checks++; if ({feat_ready, tile_idx, layer_idx} !== 4'b1000) begin errors++; $display("FAIL abort_restart: got %b expected 1000", {feat_ready, tile_idx, layer_idx}); end
        clear_job();
    endtask

    task automatic test_start_ignored();
        idle_inputs();
        start = 1; abort = 1; tick(); start = 0; abort = 0;
        tick();
        checks++; if ({busy, feat_ready} !== 2'b00) begin errors++; $display("FAIL start_with_abort: got %b expected 00", {busy, feat_ready}); end
        feat_valid = 1; out_ready_aggr = 1; comb_ready = 1;
        launch();
        for (int c = 0; c < 10; c++) begin
            if (feat_ready && tile_idx == 2'd1) break;
            tick();
        end
        feat_valid = 0;
        start = 1; tick(); tick(); start = 0;
        checks++; if ({feat_ready, in_ready_aggr, tile_idx, layer_idx} !== 5'b10010) begin errors++; $display("FAIL start_while_busy: got %b expected 10010", {feat_ready, in_ready_aggr, tile_idx, layer_idx}); end
        clear_job();
    endtask

    task automatic test_timeout();
        idle_inputs();
        feat_valid = 1; comb_ready = 1;
        launch();
        for (int c = 0; c < 5; c++) begin
            if (in_wait()) break;
            tick();
        end
`ifdef AGGR_CTRL_TIMEOUT_EN
        begin
            int wc = 0;
            for (int c = 0; c < 40; c++) begin
                if (err) break;
                if (in_wait()) wc++;
                tick();
            end
            checks++; if (wc !== 16) begin errors++; $display("FAIL to_wait_cycles: got %0d expected 16", wc); end
            checks++; if ({err, busy} !== 2'b11) begin errors++; $display("FAIL to_err_state: got %b expected 11", {err, busy}); end
            launch();
            checks++; if ({err, busy, feat_ready} !== 3'b110) begin errors++; $display("FAIL to_start_in_err: got %b expected 110", {err, busy, feat_ready}); end
            clear_job();
            checks++; if ({err, busy} !== 2'b10) begin errors++; $display("FAIL to_abort_keeps_err: got %b expected 10", {err, busy}); end
            launch();
            checks++; if ({err, feat_ready} !== 2'b01) begin errors++; $display("FAIL to_start_clears_err: got %b expected 01", {err, feat_ready}); end
        end
`else
        for (int c = 0; c < 20; c++) tick();
        checks++; if (!in_wait() || err !== 1'b0) begin errors++; $display("FAIL to_wait_forever: got wait=%0d err=%b expected 1/0", in_wait(), err); end
`endif
        clear_job();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_cleanup_idle: got %b expected 0", busy); end
    endtask

    task automatic test_async_reset();
        bit ok;
        logic [9:0] o;
        idle_inputs();
        feat_valid = 1; out_ready_aggr = 1;
        launch();
        for (int t = 0; t < 2; t++) begin
            wait_comb(10, ok);
            comb_ready = 1; tick(); comb_ready = 0;
        end
        wait_comb(10, ok);
        checks++; if ({comb_valid, tile_idx} !== 3'b110) begin errors++; $display("FAIL ar_precondition: got %b expected 110", {comb_valid, tile_idx}); end
        #3 rst_n = 0;
        #1;
        o = {feat_ready, in_ready_aggr, comb_valid, busy, done, err, tile_idx, layer_idx};
        checks++; if (o !== 10'd0) begin errors++; $display("FAIL ar_immediate: got %b expected 0", o); end
        tick();
        #3 rst_n = 1;
        tick();
        o = {feat_ready, in_ready_aggr, comb_valid, busy, done, err, tile_idx, layer_idx};
        checks++; if (o !== 10'd0) begin errors++; $display("FAIL ar_after_release: got %b expected 0", o); end
        tick();
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL ar_no_done: got %b expected 00", {busy, done}); end
    endtask

    initial begin
        test_reset();
        test_full_job();
        test_backpressure();
        test_abort();
        test_start_ignored();
        test_timeout();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
